line_window_kxk: RTL



---
 rtl/cnn_pkg.sv | 17 +
 rtl/line_buffer_ram.sv | 25 ++
 rtl/line_window_kxk.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// Shared constants and elaboration helpers for the CNN window datapath.
package cnn_pkg;

  localparam int CNN_DATA_W = 8;

  // Bit offset of window element (r,c) in a row-major KxK window.
  function automatic int win_off(input int r, input int c, input int k, input int dw);
    return (r * k + c) * dw;
  endfunction

  function automatic bit window_params_ok(input int k, input int stride, input int pad,
                                          input int pw);
    return (k % 2 == 1) && (k >= 1) && (k <= 7) && (pad >= 0) && (pad < k) &&
           (stride >= 1) && (stride <= k) && (pw >= k);
  endfunction

endpackage

// File: rtl/line_buffer_ram.sv
// Column store for the K-1 previous rows: async read, write at the same address.
// The old word is returned while the new one is written, so one port serves both.
module line_buffer_ram #(
  parameter int DEPTH = 130,
  parameter int WIDTH = 16,
  parameter int AW    = 8
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  assign rdata_o = mem_q[addr_i];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

endmodule

// File: rtl/line_window_kxk.sv
// Raster pixel stream to KxK windows with zero padding and stride; one-cycle latency,
// output register holds under out_ready=0 and stalls input via combinational in_ready.
module line_window_kxk
  import cnn_pkg::*;
#(
  parameter int DATA_W = CNN_DATA_W,
  parameter int IMG_W  = 128,
  parameter int IMG_H  = 128,
  parameter int K      = 3,
  parameter int STRIDE = 1,
  parameter int PAD    = K / 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [DATA_W-1:0]       in_data,
  output logic                    in_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [K*K*DATA_W-1:0]   out_window,
  output logic                    out_last
);

  localparam int PW     = IMG_W + 2 * PAD;
  localparam int PH     = IMG_H + 2 * PAD;
  localparam int CW     = $clog2(((PW > PH) ? PW : PH) + 1);
  localparam int LB_AW  = (PW > 1) ? $clog2(PW) : 1;
  localparam int SAFE_S = (STRIDE > 0) ? STRIDE : 1;

  localparam logic [CW-1:0] PAD_C   = CW'(PAD);
  localparam logic [CW-1:0] ROW_END = CW'(PAD + IMG_H);
  localparam logic [CW-1:0] COL_END = CW'(PAD + IMG_W);
  localparam logic [CW-1:0] PW_M1   = CW'(PW - 1);
  localparam logic [CW-1:0] PH_M1   = CW'(PH - 1);
  localparam logic [CW-1:0] KM1     = CW'(K - 1);
  localparam logic [CW-1:0] STR_M1  = CW'(SAFE_S - 1);
  localparam logic [CW-1:0] LAST_R  = CW'(PH - 1 - ((PH - K) % SAFE_S));
  localparam logic [CW-1:0] LAST_C  = CW'(PW - 1 - ((PW - K) % SAFE_S));

  generate
    if (!window_params_ok(K, STRIDE, PAD, PW)) begin : g_bad_params
      $error("line_window_kxk: illegal K/STRIDE/PAD/image size combination");
    end
  endgenerate

  logic [CW-1:0]           pr_q, pr_d, pc_q, pc_d;
  logic [CW-1:0]           rph_q, rph_d, cph_q, cph_d;
  logic [K*K*DATA_W-1:0]   win_q, win_sh;
  logic [K*K*DATA_W-1:0]   out_window_q, out_window_d;
  logic                    out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic                    interior, can_adv, step, emit, col_wrap, row_wrap;
  logic [DATA_W-1:0]       pix;
  logic [K*DATA_W-1:0]     col;

  always_comb begin
    interior = (pr_q >= PAD_C) && (pr_q < ROW_END) && (pc_q >= PAD_C) && (pc_q < COL_END);
    can_adv  = !out_valid_q || out_ready;
    step     = can_adv && (!interior || in_valid);
    pix      = interior ? in_data : '0;
    emit     = (pr_q >= KM1) && (pc_q >= KM1) && (rph_q == '0) && (cph_q == '0);
    col_wrap = (pc_q == PW_M1);
    row_wrap = (pr_q == PH_M1);
  end

  // Column at pc: K-1 stored rows (oldest at bit 0) topped by the current pixel.
  generate
    if (K > 1) begin : g_lb
      logic [(K-1)*DATA_W-1:0] lb_rdata;
      line_buffer_ram #(
        .DEPTH (PW),
        .WIDTH ((K - 1) * DATA_W),
        .AW    (LB_AW)
      ) u_lb (
        .clk     (clk),
        .we_i    (step),
        .addr_i  (pc_q[LB_AW-1:0]),
        .wdata_i (col[K*DATA_W-1:DATA_W]),
        .rdata_o (lb_rdata)
      );
      assign col = {pix, lb_rdata};
    end else begin : g_no_lb
      assign col = pix;
    end
  endgenerate

  // Phase counters track (pos-(K-1)) % STRIDE without a divider.
  always_comb begin
    pr_d  = pr_q;
    pc_d  = pc_q;
    rph_d = rph_q;
    cph_d = cph_q;
    if (step) begin
      if (col_wrap) begin
        pc_d  = '0;
        cph_d = '0;
        if (row_wrap) begin
          pr_d  = '0;
          rph_d = '0;
        end else begin
          pr_d  = pr_q + 1'b1;
          rph_d = (pr_q < KM1 || rph_q == STR_M1) ? '0 : rph_q + 1'b1;
        end
      end else begin
        pc_d  = pc_q + 1'b1;
        cph_d = (pc_q < KM1 || cph_q == STR_M1) ? '0 : cph_q + 1'b1;
      end
    end
  end

  always_comb begin
    win_sh = win_q;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        if (c < K - 1) begin
          win_sh[win_off(r, c, K, DATA_W) +: DATA_W] = win_q[win_off(r, c + 1, K, DATA_W) +: DATA_W];
        end else begin
          win_sh[win_off(r, c, K, DATA_W) +: DATA_W] = col[r*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    out_last_d   = out_last_q;
    out_window_d = out_window_q;
    if (step && emit) begin
      out_valid_d  = 1'b1;
      out_last_d   = (pr_q == LAST_R) && (pc_q == LAST_C);
      out_window_d = win_sh;
    end else if (out_ready) begin
      out_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pr_q         <= '0;
      pc_q         <= '0;
      rph_q        <= '0;
      cph_q        <= '0;
      win_q        <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_window_q <= '0;
    end else begin
      pr_q         <= pr_d;
      pc_q         <= pc_d;
      rph_q        <= rph_d;
      cph_q        <= cph_d;
      if (step) win_q <= win_sh;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      out_window_q <= out_window_d;
    end
  end

  assign in_ready   = can_adv && interior;
  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;
  assign out_window = out_window_q;

endmodule
